// File: rtl/shift_pkg.sv
// Shared constants and types for the multi-cycle shift sequencer.
package shift_pkg;

  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ARI = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;

  localparam int DATA_W_DFLT = 8;
  // Largest amount a single pass can apply (DATA_W-1).
  localparam int MAX_STEP    = DATA_W_DFLT - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift pass of 0..7 positions: a 1/2/4 log-stage mux chain.
module shift_step
  import shift_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [2:0]        amt_i,
  input  logic              lr_i,
  input  logic [1:0]        mode_i,
  output logic [DATA_W-1:0] data_o
);

  logic rot, ari;
  logic [3:0][DATA_W-1:0] stg;

  assign rot    = (mode_i == MODE_ROT);
  assign ari    = (mode_i == MODE_ARI);
  assign stg[0] = data_i;

  for (genvar s = 0; s < 3; s++) begin : g_stage
    localparam int SH = 1 << s;
    logic [SH-1:0]     lfill, rfill;
    logic [DATA_W-1:0] lsh, rsh;

    // Arithmetic only matters to the right; left arithmetic is logical.
    assign lfill = rot ? stg[s][DATA_W-1 -: SH] : '0;
    assign rfill = rot ? stg[s][SH-1:0]
                 : ari ? {SH{stg[s][DATA_W-1]}} : '0;
    assign lsh   = {stg[s][DATA_W-1-SH:0], lfill};
    assign rsh   = {rfill, stg[s][DATA_W-1:SH]};
    assign stg[s+1] = amt_i[s] ? (lr_i ? rsh : lsh) : stg[s];
  end

  assign data_o = stg[3];

endmodule

// File: rtl/shift_seq.sv
// Shift sequencer: applies shifts up to 31 as repeated <=7-position passes,
// with valid/ready on both command input and result output.
module shift_seq
  import shift_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int AMT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              in_lr,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [AMT_W-1:0]  rem_q, rem_d;
  logic              lr_q, lr_d;
  logic [1:0]        mode_q, mode_d;
  logic [2:0]        step;
  logic [DATA_W-1:0] shifted;

  assign step = (rem_q > AMT_W'(MAX_STEP)) ? 3'(MAX_STEP) : rem_q[2:0];

  shift_step #(.DATA_W(DATA_W)) u_step (
    .data_i (acc_q),
    .amt_i  (step),
    .lr_i   (lr_q),
    .mode_i (mode_q),
    .data_o (shifted)
  );

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_data  = acc_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    lr_d    = lr_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: if (in_valid) begin
        acc_d   = in_data;
        rem_d   = in_amt;
        lr_d    = in_lr;
        mode_d  = in_mode;
        state_d = (in_amt != '0) ? RUN : DONE;
      end
      RUN: begin
        acc_d = shifted;
        rem_d = rem_q - AMT_W'(step);
        if (rem_d == '0) state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      lr_q    <= 1'b0;
      mode_q  <= MODE_LOG;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      lr_q    <= lr_d;
      mode_q  <= mode_d;
    end
  end

endmodule
